// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory request unit.
//   lsu_size_t  : access size encoding carried on the request and writeback paths
//   lsu_state_t : lsu_mem_req transaction state
package lsu_pkg;

   typedef enum logic [1:0] {
      SizeByte    = 2'b00,
      SizeHalf    = 2'b01,
      SizeWord    = 2'b10,
      SizeInvalid = 2'b11
   } lsu_size_t;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StReq     = 2'b01,
      StWaitRsp = 2'b10,
      StDone    = 2'b11
   } lsu_state_t;

endpackage

// File: rtl/lsu_mem_req_if.sv
// Bundle of all lsu_mem_req signals except clock and reset.
//   Upstream request : req_valid/req_ready, is_nop, is_load, addr, wdata, size, zero_ext, rd
//   Memory request   : mem_req_valid/mem_req_ready, mem_addr, mem_we, mem_be, mem_wdata
//   Memory response  : mem_rsp_valid, mem_rdata
//   Writeback        : wb_valid, wb_is_load, wb_rd, wb_size, wb_zero_ext, wb_data, wb_fault
// Modports:
//   master : the request unit itself (it masters the memory bus)
//   slave  : its environment (upstream LSU, data memory, writeback)
interface lsu_mem_req_if;
   import lsu_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic        is_nop;
   logic        is_load;
   logic [31:0] addr;
   logic [31:0] wdata;
   lsu_size_t   size;
   logic        zero_ext;
   logic [4:0]  rd;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;

   logic        wb_valid;
   logic        wb_is_load;
   logic [4:0]  wb_rd;
   lsu_size_t   wb_size;
   logic        wb_zero_ext;
   logic [31:0] wb_data;
   logic        wb_fault;

   modport master (
      input  req_valid, is_nop, is_load, addr, wdata, size, zero_ext, rd,
      input  mem_req_ready, mem_rsp_valid, mem_rdata,
      output req_ready,
      output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
      output wb_valid, wb_is_load, wb_rd, wb_size, wb_zero_ext, wb_data, wb_fault
   );

   modport slave (
      output req_valid, is_nop, is_load, addr, wdata, size, zero_ext, rd,
      output mem_req_ready, mem_rsp_valid, mem_rdata,
      input  req_ready,
      input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
      input  wb_valid, wb_is_load, wb_rd, wb_size, wb_zero_ext, wb_data, wb_fault
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the LSU memory request unit.
//   size, offset, wdata -> be, wdata_lanes : store byte enables and lane-replicated data
//   rsp_offset, rdata   -> rdata_shifted   : load word shifted down to bit 0
// offset must already be the effective (possibly forced-aligned) byte offset.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_size_t   size,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lanes,
   input  logic [1:0]  rsp_offset,
   input  logic [31:0] rdata,
   output logic [31:0] rdata_shifted
);

   always_comb begin
      be          = 4'b0000;
      wdata_lanes = wdata;
      case (size)
         SizeByte: begin
            be          = 4'b0001 << offset;
            wdata_lanes = {4{wdata[7:0]}};
         end
         SizeHalf: begin
            be          = 4'b0011 << offset;
            wdata_lanes = {2{wdata[15:0]}};
         end
         SizeWord: begin
            be          = 4'b1111;
            wdata_lanes = wdata;
         end
         default: begin
            be          = 4'b0000;
            wdata_lanes = wdata;
         end
      endcase
   end

   always_comb begin
      rdata_shifted = rdata >> {rsp_offset, 3'b000};
   end

endmodule

// File: rtl/lsu_mem_req.sv
// LSU memory request unit: accepts one load/store at a time, issues it to data memory over a
// valid/ready handshake, waits for load data and emits a one-cycle writeback pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lsu_mem_req_if.master (upstream request, memory request/response, writeback)
// Configuration macro LSU_MISALIGN_CHECK_EN:
//   defined   : misaligned half/word accesses fault and skip memory
//   undefined : misaligned half/word accesses have their low address bits forced to zero
module lsu_mem_req
   import lsu_pkg::*;
(
   input logic           clk,
   input logic           rst,
   lsu_mem_req_if.master bus
);

   lsu_state_t  state_q, state_d;
   lsu_size_t   req_size;
   logic        accept;
   logic        misalign;
   logic        fault;
   logic [1:0]  eff_off;
   logic [3:0]  be_lanes;
   logic [31:0] wdata_lanes;
   logic [31:0] rdata_shifted;

   logic [31:0] mem_addr_q;
   logic        mem_we_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;
   logic [1:0]  off_q;
   logic        wb_is_load_q;
   logic [4:0]  wb_rd_q;
   lsu_size_t   wb_size_q;
   logic        wb_zero_ext_q;
   logic [31:0] wb_data_q;
   logic        wb_fault_q;

   assign req_size = bus.size;
   assign accept   = (state_q == StIdle) && bus.req_valid;

`ifdef LSU_MISALIGN_CHECK_EN
   always_comb begin
      misalign = ((req_size == SizeHalf) && bus.addr[0]) ||
                 ((req_size == SizeWord) && (bus.addr[1:0] != 2'b00));
      eff_off  = bus.addr[1:0];
   end
`else
   always_comb begin
      misalign = 1'b0;
      case (req_size)
         SizeHalf: eff_off = {bus.addr[1], 1'b0};
         SizeWord: eff_off = 2'b00;
         default:  eff_off = bus.addr[1:0];
      endcase
   end
`endif

   assign fault = (req_size == SizeInvalid) || misalign;

   lsu_lane_align u_lane_align (
      .size          (req_size),
      .offset        (eff_off),
      .wdata         (bus.wdata),
      .be            (be_lanes),
      .wdata_lanes   (wdata_lanes),
      .rsp_offset    (off_q),
      .rdata         (bus.mem_rdata),
      .rdata_shifted (rdata_shifted)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (bus.req_valid && !bus.is_nop) begin
               state_d = fault ? StDone : StReq;
            end
         end
         StReq: begin
            if (bus.mem_req_ready) begin
               state_d = wb_is_load_q ? StWaitRsp : StDone;
            end
         end
         StWaitRsp: begin
            if (bus.mem_rsp_valid) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         mem_addr_q    <= '0;
         mem_we_q      <= 1'b0;
         mem_be_q      <= '0;
         mem_wdata_q   <= '0;
         off_q         <= '0;
         wb_is_load_q  <= 1'b0;
         wb_rd_q       <= '0;
         wb_size_q     <= SizeByte;
         wb_zero_ext_q <= 1'b0;
         wb_data_q     <= '0;
         wb_fault_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         // Request fields are captured once at accept so the memory outputs stay
         // stable for the whole handshake regardless of upstream activity.
         if (accept) begin
            mem_addr_q    <= {bus.addr[31:2], 2'b00};
            mem_we_q      <= !bus.is_load;
            mem_be_q      <= be_lanes;
            mem_wdata_q   <= wdata_lanes;
            off_q         <= eff_off;
            wb_is_load_q  <= bus.is_load;
            wb_rd_q       <= bus.rd;
            wb_size_q     <= req_size;
            wb_zero_ext_q <= bus.zero_ext;
            wb_data_q     <= '0;
            wb_fault_q    <= !bus.is_nop && fault;
         end
         if ((state_q == StWaitRsp) && bus.mem_rsp_valid) begin
            wb_data_q <= rdata_shifted;
         end
      end
   end

   always_comb begin
      bus.req_ready     = (state_q == StIdle);
      bus.mem_req_valid = (state_q == StReq);
      bus.mem_addr      = mem_addr_q;
      bus.mem_we        = mem_we_q;
      bus.mem_be        = mem_be_q;
      bus.mem_wdata     = mem_wdata_q;
      bus.wb_valid      = (state_q == StDone);
      bus.wb_is_load    = wb_is_load_q;
      bus.wb_rd         = wb_rd_q;
      bus.wb_size       = wb_size_q;
      bus.wb_zero_ext   = wb_zero_ext_q;
      bus.wb_data       = wb_data_q;
      bus.wb_fault      = wb_fault_q;
   end

endmodule

// File: doc/lsu_mem_req.md
# lsu_mem_req

Load/store memory request unit at the memory-facing end of the LSU. It accepts one decoded load or store per transaction, aligns store data onto byte lanes, and generates byte enables. It issues the request to data memory over a valid/ready handshake and waits for load responses. Load data is shifted down to bit 0 and handed to LSU writeback, which then performs zero or sign extension and the register-file write.

## Interface
- No parameters; data and address widths are fixed at 32 bits.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: upstream request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `is_nop` in 1: request is a NOP; consumed with no memory traffic.
- `is_load` in 1: 1 = load, 0 = store.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `size` in 2: 00 byte, 01 half, 10 word, 11 invalid.
- `zero_ext` in 1: unsigned-load flag; passed through to writeback.
- `rd` in 5: load destination register; passed through.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_we` out 1: 1 for stores.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rsp_valid` in 1: load response valid.
- `mem_rdata` in 32: load response word.
- `wb_valid` out 1: one-cycle completion pulse toward writeback.
- `wb_is_load`, `wb_rd`, `wb_size`, `wb_zero_ext` out 1/5/2/1: registered copies of the request fields.
- `wb_data` out 32: load word shifted right by `8*addr[1:0]`; 0 for stores.
- `wb_fault` out 1: access faulted; no memory access was performed.

## Operation
- States: IDLE, REQ, WAIT_RSP, DONE.
- **IDLE:** `req_ready=1`. On `req_valid`, all request fields are latched.
  - NOP: the unit stays in IDLE and produces no memory traffic and no `wb_valid`.
  - Fault: next state is DONE.
  - Otherwise: next state is REQ.
- **REQ:** `mem_req_valid=1`, with the request held stable until `mem_req_ready`.
  - On handshake, a load goes to WAIT_RSP and a store goes to DONE.
- **WAIT_RSP:** the unit waits on `mem_rsp_valid` for as many cycles as it takes.
  - On response, `mem_rdata >> (8*addr[1:0])` is captured into `wb_data` and the state goes to DONE.
  - `mem_rsp_valid` is ignored in every other state.
- **DONE:** `wb_valid=1` for exactly one cycle, then the state returns to IDLE.
- **Byte enables and store data:**
  - Byte: `mem_be = 4'b0001 << addr[1:0]`, `mem_wdata = {4{wdata[7:0]}}`.
  - Half: `mem_be = 4'b0011 << addr[1:0]`, `mem_wdata = {2{wdata[15:0]}}`.
  - Word: `mem_be = 4'b1111`, `mem_wdata = wdata`.
- **Load data:** bits above the access size in `wb_data` are don't-care; writeback masks or extends them.
- **Invalid size:** `size=11` always faults, with or without the configuration macro.

## Timing
- **Reset values:**
  - State is IDLE.
  - `req_ready=1`.
  - `mem_req_valid`, `mem_we`, `mem_be`, `wb_valid` and `wb_fault` are 0.
  - `mem_addr`, `mem_wdata`, `wb_data` and all `wb_*` fields are 0.
- **Reset mid-operation:** the unit returns to IDLE on the next edge and drops `mem_req_valid`. A response still outstanding is discarded because it arrives in IDLE.
- **Load, zero wait:** accept at edge 0; REQ in cycle 1 with handshake; response in cycle 2; `wb_valid` in cycle 3. Minimum load latency is 3 cycles.
- **Store, zero wait:** accept at edge 0; handshake in cycle 1; `wb_valid` in cycle 2.
- **Fault:** accept at edge 0; `wb_valid` and `wb_fault` in cycle 1; `mem_req_valid` is never asserted.
- **Occupancy:** only one transaction is in flight at a time. `req_ready` is low from the cycle after acceptance through DONE.
- **Request stability:** `mem_*` request outputs are registered and stay constant while `mem_req_valid && !mem_req_ready`.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A half access with `addr[0]=1` faults.
  - A word access with `addr[1:0]!=0` faults.
  - Faulting accesses skip memory and complete with `wb_fault=1`.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - A misaligned half has `addr[0]` forced to 0; a misaligned word has `addr[1:0]` forced to 0.
  - The access then proceeds normally.
  - `wb_fault` asserts only for `size=11`.

## Structure
- Shared package `lsu_pkg`: `lsu_size_t` enum (BYTE, HALF, WORD, INVALID) and the `lsu_mem_req` state enum.
- Sub-module `lsu_lane_align`: purely combinational. It computes `mem_be` and `mem_wdata` from size, addr and wdata, and computes the load right-shift. The FSM and registers live in `lsu_mem_req`.

## Test plan
- **SB store:** `addr=0x1003`, `wdata=0xAB`, `size=00`, `mem_req_ready=1` → `mem_addr=0x1000`, `mem_be=1000`, `mem_wdata=0xABABABAB`, `mem_we=1`; `wb_valid` 2 cycles after accept with `wb_is_load=0`.
- **LH load:** `addr=0x2002`, `size=01`, `rd=5`; response `0xBEEF1234` two cycles after the handshake → `wb_data[15:0]=0xBEEF`, `wb_rd=5`, one `wb_valid` pulse.
- **Backpressure:** `mem_req_ready` held low for 4 cycles → `mem_req_valid` and all `mem_*` outputs stay stable, `req_ready=0`, and a new `req_valid` is not accepted.
- **Misaligned LW:** `addr=0x3001`, `size=10`, macro defined → no `mem_req_valid`; `wb_fault=1` and `wb_valid` 1 cycle after accept.
  - Same access, macro undefined → `mem_addr=0x3000`, `mem_be=1111`, `wb_fault=0`.
- **Reset in WAIT_RSP:** `rst` for 1 cycle, then `mem_rsp_valid` → no `wb_valid` is produced, `req_ready=1`, and the next load completes normally.
- **NOP and size=11:** NOP accepted → no `mem_req_valid`, no `wb_valid`. Request with `size=11` → `wb_fault=1` in both macro builds.
